// File: rtl/pwm_sequencer.sv
// Run-time sequencer for the DPWM stage: enable, soft-start ramp, period-aligned updates, over-current shutdown.
// Optional auto-retry after a fault is enabled by defining PWM_SEQ_AUTO_RETRY_EN.
module pwm_sequencer #(
  parameter int          DW        = 10,
  parameter int          RAMP_DIV  = 4,
  parameter int          RAMP_STEP = 2,
  parameter int          DUTY_MAX  = 900,
  parameter logic [12:0] OC_LIMIT  = 13'd3000,
  parameter int          OC_FILT   = 8
`ifdef PWM_SEQ_AUTO_RETRY_EN
  , parameter int        RETRY_PERIODS = 1000
`endif
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          start,
  input  logic          stop,
  input  logic          fault_clr,
  input  logic [DW-1:0] duty_tgt,
  input  logic [3:0]    freq_sel,
  input  logic          period_end,
  input  logic [12:0]   iout_err,
  output logic          pwm_en,
  output logic [DW-1:0] duty_out,
  output logic [3:0]    freq_out,
  output logic [2:0]    state,
  output logic          fault
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SOFTSTART = 3'd1;
  localparam logic [2:0] ST_RUN       = 3'd2;
  localparam logic [2:0] ST_RAMPDOWN  = 3'd3;
  localparam logic [2:0] ST_FAULT     = 3'd4;
`ifdef PWM_SEQ_AUTO_RETRY_EN
  localparam logic [2:0] ST_COOLDOWN  = 3'd5;
  localparam int         CCW          = $clog2(RETRY_PERIODS + 1);
`endif

  localparam int          RCW        = $clog2(RAMP_DIV + 1);
  localparam int          OCW        = $clog2(OC_FILT + 1);
  localparam logic [DW-1:0] DUTY_MAX_C = DW'(DUTY_MAX);
  localparam logic [DW-1:0] STEP_C     = DW'(RAMP_STEP);

  logic [2:0]     state_q, state_d;
  logic           pwm_en_q, pwm_en_d;
  logic [DW-1:0]  duty_q, duty_d;
  logic [3:0]     freq_q, freq_d;
  logic           fault_q, fault_d;
  logic [RCW-1:0] ramp_q, ramp_d;
  logic [OCW-1:0] oc_cnt_q, oc_cnt_d;
`ifdef PWM_SEQ_AUTO_RETRY_EN
  logic [CCW-1:0] cool_q, cool_d;
  logic           cool_last;
`endif

  logic [DW-1:0] tgt;
  logic [3:0]    freq_sat;
  logic [DW:0]   duty_up;
  logic [DW-1:0] duty_dn;
  logic          ramp_last;
  logic          oc_over;
  logic          oc_trip;
  logic          run_req;

  assign tgt       = (duty_tgt > DUTY_MAX_C) ? DUTY_MAX_C : duty_tgt;
  assign freq_sat  = (freq_sel > 4'd10) ? 4'd10 : freq_sel;
  assign duty_up   = {1'b0, duty_q} + {1'b0, STEP_C};
  assign duty_dn   = (duty_q > STEP_C) ? (duty_q - STEP_C) : '0;
  assign ramp_last = (ramp_q == RCW'(RAMP_DIV - 1));
  assign oc_over   = (iout_err > OC_LIMIT);
  assign run_req   = start && !stop;
`ifdef PWM_SEQ_AUTO_RETRY_EN
  assign cool_last = (cool_q == CCW'(RETRY_PERIODS - 1));
`endif

  // Consecutive over-limit cycles; saturates so a sustained fault keeps the trip armed.
  assign oc_cnt_d = !oc_over ? '0 :
                    (oc_cnt_q == OCW'(OC_FILT)) ? oc_cnt_q : oc_cnt_q + 1'b1;
  assign oc_trip  = oc_over && (oc_cnt_q >= OCW'(OC_FILT - 1)) && pwm_en_q;

  always_comb begin
    state_d  = state_q;
    pwm_en_d = pwm_en_q;
    duty_d   = duty_q;
    freq_d   = freq_q;
    fault_d  = fault_q;
    ramp_d   = ramp_q;
`ifdef PWM_SEQ_AUTO_RETRY_EN
    cool_d   = cool_q;
`endif
    if (oc_trip) begin
      state_d  = ST_FAULT;
      fault_d  = 1'b1;
      pwm_en_d = 1'b0;
      duty_d   = '0;
      ramp_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pwm_en_d = 1'b0;
          duty_d   = '0;
          freq_d   = freq_sat;
          ramp_d   = '0;
          if (run_req && !fault_q) begin
            state_d  = ST_SOFTSTART;
            pwm_en_d = 1'b1;
          end
        end
        ST_SOFTSTART: begin
          if (!run_req) begin
            state_d = ST_RAMPDOWN;
            ramp_d  = '0;
          end else if (period_end) begin
            if (duty_q >= tgt) begin
              duty_d  = tgt;
              state_d = ST_RUN;
              ramp_d  = '0;
            end else if (ramp_last) begin
              ramp_d = '0;
              if (duty_up >= {1'b0, tgt}) begin
                duty_d  = tgt;
                state_d = ST_RUN;
              end else begin
                duty_d = duty_up[DW-1:0];
              end
            end else begin
              ramp_d = ramp_q + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!run_req) begin
            state_d = ST_RAMPDOWN;
            ramp_d  = '0;
          end else if (period_end) begin
            duty_d = tgt;
            freq_d = freq_sat;
          end
        end
        ST_RAMPDOWN: begin
          if (period_end) begin
            if (duty_q == '0) begin
              state_d  = ST_IDLE;
              pwm_en_d = 1'b0;
              ramp_d   = '0;
            end else if (ramp_last) begin
              ramp_d = '0;
              duty_d = duty_dn;
              if (duty_dn == '0) begin
                state_d  = ST_IDLE;
                pwm_en_d = 1'b0;
              end
            end else begin
              ramp_d = ramp_q + 1'b1;
            end
          end
        end
        ST_FAULT: begin
          pwm_en_d = 1'b0;
          duty_d   = '0;
          if (fault_clr && !oc_over) begin
            state_d = ST_IDLE;
            fault_d = 1'b0;
          end
`ifdef PWM_SEQ_AUTO_RETRY_EN
          else begin
            state_d = ST_COOLDOWN;
            cool_d  = '0;
          end
`endif
        end
`ifdef PWM_SEQ_AUTO_RETRY_EN
        ST_COOLDOWN: begin
          pwm_en_d = 1'b0;
          duty_d   = '0;
          if (fault_clr) begin
            state_d = ST_IDLE;
            fault_d = 1'b0;
          end else if (period_end) begin
            if (cool_last) begin
              cool_d = '0;
              if (run_req && !oc_over) begin
                state_d  = ST_SOFTSTART;
                fault_d  = 1'b0;
                pwm_en_d = 1'b1;
                ramp_d   = '0;
              end else begin
                state_d = ST_FAULT;
              end
            end else begin
              cool_d = cool_q + 1'b1;
            end
          end
        end
`endif
        default: begin
          state_d  = ST_IDLE;
          pwm_en_d = 1'b0;
          duty_d   = '0;
          ramp_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      pwm_en_q <= 1'b0;
      duty_q   <= '0;
      freq_q   <= 4'd7;
      fault_q  <= 1'b0;
      ramp_q   <= '0;
      oc_cnt_q <= '0;
`ifdef PWM_SEQ_AUTO_RETRY_EN
      cool_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pwm_en_q <= pwm_en_d;
      duty_q   <= duty_d;
      freq_q   <= freq_d;
      fault_q  <= fault_d;
      ramp_q   <= ramp_d;
      oc_cnt_q <= oc_cnt_d;
`ifdef PWM_SEQ_AUTO_RETRY_EN
      cool_q   <= cool_d;
`endif
    end
  end

  assign pwm_en   = pwm_en_q;
  assign duty_out = duty_q;
  assign freq_out = freq_q;
  assign state    = state_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed bench for pwm_sequencer: reset, soft-start, period-aligned updates, ramp-down, over-current trip.
module tb_pwm_sequencer;

  logic        CLOCK_50;
  logic        resetn;
  logic        start;
  logic        stop;
  logic        fault_clr;
  logic [9:0]  duty_tgt;
  logic [3:0]  freq_sel;
  logic        period_end;
  logic [12:0] iout_err;
  logic        pwm_en;
  logic [9:0]  duty_out;
  logic [3:0]  freq_out;
  logic [2:0]  state;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;

  pwm_sequencer dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .start      (start),
    .stop       (stop),
    .fault_clr  (fault_clr),
    .duty_tgt   (duty_tgt),
    .freq_sel   (freq_sel),
    .period_end (period_end),
    .iout_err   (iout_err),
    .pwm_en     (pwm_en),
    .duty_out   (duty_out),
    .freq_out   (freq_out),
    .state      (state),
    .fault      (fault)
  );

  // clock / reset
  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pe_pulse(input int gap);
    ticks(gap);
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
  endtask

  task automatic chk_outs(input string tag, input int st, input int en, input int dty, input int flt);
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_pwm_en"}, 32'(pwm_en), 32'(en));
    chk({tag, "_duty"}, 32'(duty_out), 32'(dty));
    chk({tag, "_fault"}, 32'(fault), 32'(flt));
  endtask

  initial begin
    resetn     = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    fault_clr  = 1'b0;
    duty_tgt   = 10'd0;
    freq_sel   = 4'd12;
    period_end = 1'b0;
    iout_err   = 13'd0;
    ticks(3);
    chk_outs("rst", 0, 0, 0, 0);
    chk("rst_freq", 32'(freq_out), 32'd7);
    resetn = 1'b1;
    tick();
    chk("idle_freq_sat", 32'(freq_out), 32'd10);
    freq_sel = 4'd7;
    tick();
    chk("idle_freq", 32'(freq_out), 32'd7);

    // soft-start to 20 with period_end every 322 cycles
    duty_tgt = 10'd20;
    start    = 1'b1;
    tick();
    chk_outs("ss_entry", 1, 1, 0, 0);
    for (int k = 1; k <= 40; k++) begin
      pe_pulse(321);
      chk($sformatf("ss_duty_%0d", k), 32'(duty_out), 32'(2 * (k / 4)));
      chk($sformatf("ss_state_%0d", k), 32'(state), (k == 40) ? 32'd2 : 32'd1);
    end

    // period-aligned frequency and duty updates in RUN
    freq_sel = 4'd3;
    ticks(5);
    chk("run_freq_hold", 32'(freq_out), 32'd7);
    pe_pulse(3);
    chk("run_freq_3", 32'(freq_out), 32'd3);
    freq_sel = 4'd15;
    pe_pulse(3);
    chk("run_freq_sat", 32'(freq_out), 32'd10);
    duty_tgt = 10'd1000;
    tick();
    chk("run_duty_hold", 32'(duty_out), 32'd20);
    pe_pulse(2);
    chk("run_duty_clamp", 32'(duty_out), 32'd900);
    duty_tgt = 10'd20;
    pe_pulse(2);
    chk("run_duty_20", 32'(duty_out), 32'd20);
    pulse_clr();
    chk("run_clr_ignored", 32'(state), 32'd2);

    // orderly stop from duty 20
    stop = 1'b1;
    tick();
    chk_outs("rd_entry", 3, 1, 20, 0);
    for (int k = 1; k <= 40; k++) begin
      pe_pulse(2);
      chk($sformatf("rd_duty_%0d", k), 32'(duty_out), 32'(20 - 2 * (k / 4)));
      chk($sformatf("rd_state_%0d", k), 32'(state), (k == 40) ? 32'd0 : 32'd3);
    end
    chk("rd_pwm_off", 32'(pwm_en), 32'd0);
    stop  = 1'b0;
    start = 1'b0;
    tick();

    // zero target reaches RUN on first period_end
    duty_tgt = 10'd0;
    start    = 1'b1;
    tick();
    chk("z_state_ss", 32'(state), 32'd1);
    pe_pulse(2);
    chk_outs("z_run", 2, 1, 0, 0);
    duty_tgt = 10'd300;
    pe_pulse(2);
    chk("oc_duty_300", 32'(duty_out), 32'd300);

    // over-current filter
    iout_err = 13'd3000;
    ticks(12);
    chk_outs("oc_at_limit", 2, 1, 300, 0);
    iout_err = 13'd3001;
    ticks(7);
    iout_err = 13'd0;
    tick();
    chk_outs("oc_7cyc", 2, 1, 300, 0);
    iout_err = 13'd3001;
    ticks(7);
    chk_outs("oc_pre_trip", 2, 1, 300, 0);
    tick();
    chk_outs("oc_trip", 4, 0, 0, 1);
`ifndef PWM_SEQ_AUTO_RETRY_EN
    pulse_clr();
    chk_outs("oc_clr_blocked", 4, 0, 0, 1);
    iout_err = 13'd0;
    start    = 1'b0;
    tick();
    chk("oc_fault_hold", 32'(state), 32'd4);
    pulse_clr();
    chk_outs("oc_clr", 0, 0, 0, 0);
`else
    iout_err = 13'd0;
    tick();
    chk_outs("ar_cool", 5, 0, 0, 1);
    period_end = 1'b1;
    ticks(999);
    chk("ar_cool_999", 32'(state), 32'd5);
    tick();
    period_end = 1'b0;
    chk_outs("ar_retry", 1, 1, 0, 0);
    start = 1'b0;
    tick();
    pe_pulse(1);
    chk("ar_idle", 32'(state), 32'd0);
`endif

    // stop and over-current trip in the same cycle
    duty_tgt = 10'd0;
    start    = 1'b1;
    tick();
    pe_pulse(1);
    chk("st_run", 32'(state), 32'd2);
    iout_err = 13'd3001;
    ticks(7);
    stop = 1'b1;
    tick();
    chk_outs("st_trip", 4, 0, 0, 1);
    iout_err = 13'd0;
    stop     = 1'b0;
    start    = 1'b0;
    tick();
    pulse_clr();
    chk_outs("st_clr", 0, 0, 0, 0);

    // asynchronous reset in RUN at duty 300
    start    = 1'b1;
    freq_sel = 4'd3;
    tick();
    pe_pulse(1);
    duty_tgt = 10'd300;
    pe_pulse(1);
    chk_outs("ar_pre", 2, 1, 300, 0);
    chk("ar_pre_freq", 32'(freq_out), 32'd3);
    #5;
    resetn = 1'b0;
    #1;
    chk_outs("async_rst", 0, 0, 0, 0);
    chk("async_rst_freq", 32'(freq_out), 32'd7);
    start = 1'b0;
    tick();
    resetn = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
